cmsdk_ahb_to_flash_linebuf: RTL and testbench

CMSDK_AHB_TO_FLASH_LINEBUF -- requirements
Module: cmsdk_ahb_to_flash_linebuf

---
 rtl/cmsdk_ahb_flash_pkg.sv | 20 ++
 rtl/cmsdk_flash_line_buffer.sv | 64 ++++++
 rtl/cmsdk_ahb_to_flash_linebuf.sv | 116 +++++++++++
 tb/tb_cmsdk_ahb_to_flash_linebuf.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmsdk_ahb_flash_pkg.sv
// Shared constants for the AHB-to-flash line-buffer bridge: FSM encoding,
// AHB transfer/response codes and the wait-state counter width.
package cmsdk_ahb_flash_pkg;
  localparam int WSW = 2;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ERR1  = 2'd2,
    ST_ERR2  = 2'd3
  } state_e;
endpackage

// File: rtl/cmsdk_flash_line_buffer.sv
// Single flash-line store: data, tag and valid, word select and invalidate
// tracking so an invalidate seen at any point of a fetch blocks that fill.
module cmsdk_flash_line_buffer #(
  parameter int TW   = 12,
  parameter int LW   = 2,
  parameter int FW   = 128,
  parameter int WSEL = 2
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic [TW-1:0]   lookup_tag,
  input  logic [WSEL-1:0] word_sel,
  input  logic            fetching,
  input  logic            fill,
  input  logic            inv,
  input  logic [TW-1:0]   fill_tag,
  input  logic [FW-1:0]   fill_data,
  output logic            hit,
  output logic [31:0]     buf_word,
  output logic [31:0]     fill_word
);
  localparam int NW = 1 << LW;

  logic [NW-1:0][31:0] data_q;
  logic [NW-1:0][31:0] fill_words;
  logic [TW-1:0]       tag_q;
  logic                valid_q;
  logic                inv_seen;

  assign fill_words = fill_data;
  assign hit        = valid_q & (tag_q == lookup_tag);

  generate
    if (LW == 0) begin : g_one_word
      logic unused_sel;
      assign unused_sel = ^word_sel;
      assign buf_word   = data_q[0];
      assign fill_word  = fill_words[0];
    end else begin : g_multi_word
      assign buf_word  = data_q[word_sel];
      assign fill_word = fill_words[word_sel];
    end
  endgenerate

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tag_q    <= '0;
      valid_q  <= 1'b0;
      inv_seen <= 1'b0;
    end else if (fill) begin
      tag_q    <= fill_tag;
      valid_q  <= ~(inv | inv_seen);
      inv_seen <= 1'b0;
    end else begin
      if (inv)            valid_q  <= 1'b0;
      if (inv && fetching) inv_seen <= 1'b1;
    end
  end

  // Data is qualified by valid, so it needs no reset.
  always_ff @(posedge HCLK) begin
    if (fill) data_q <= fill_words;
  end
endmodule

// File: rtl/cmsdk_ahb_to_flash_linebuf.sv
// AHB-Lite read-only flash bridge with a one-line buffer: zero-wait hits,
// FLASHWS+1 cycle misses, two-cycle ERROR on writes.
module cmsdk_ahb_to_flash_linebuf
  import cmsdk_ahb_flash_pkg::*;
#(
  parameter int AW = 16,
  parameter int LW = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic [AW-1:0]          HADDR,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HSIZE,
  input  logic [3:0]             HPROT,
  input  logic                   HWRITE,
  input  logic [31:0]            HWDATA,
  input  logic                   HREADY,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [31:0]            HRDATA,
  input  logic [WSW-1:0]         FLASHWS,
  input  logic                   FLASHINV,
  output logic                   FLASHREQ,
  output logic [AW-3-LW:0]       FLASHADDR,
  input  logic [(32<<LW)-1:0]    FLASHRDATA
);
  localparam int FW   = 32 << LW;
  localparam int TW   = AW - 2 - LW;
  localparam int WSEL = (LW == 0) ? 1 : LW;

  state_e          state;
  logic [WSW-1:0]  cnt;
  logic            rd_pend;
  logic [TW-1:0]   tag_q;
  logic [WSEL-1:0] word_q;
  logic [WSEL-1:0] addr_word;
  logic            act, act_rd, act_wr;
  logic            hit, rd_hit, fetch_act, fill;
  logic [31:0]     buf_word, fill_word;
  logic            unused;

  assign unused = ^{HSIZE, HPROT, HWDATA, HADDR[1:0], HTRANS[0]};

  generate
    if (LW == 0) begin : g_no_word
      assign addr_word = '0;
    end else begin : g_word
      assign addr_word = HADDR[1+LW:2];
    end
  endgenerate

  assign act    = HSEL & HTRANS[1] & HREADY;
  assign act_rd = act & ~HWRITE;
  assign act_wr = act & HWRITE;

  // A miss is handled as a fetch from its very first data-phase cycle.
  assign rd_hit    = (state == ST_IDLE) & rd_pend & hit;
  assign fetch_act = (state == ST_FETCH) | ((state == ST_IDLE) & rd_pend & ~hit);
  assign fill      = fetch_act & (cnt == '0);

  assign HREADYOUT = (state == ST_ERR1) ? 1'b0 : (fetch_act ? (cnt == '0) : 1'b1);
  assign HRESP     = ((state == ST_ERR1) | (state == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
  assign HRDATA    = rd_hit ? buf_word : (fill ? fill_word : 32'h0);
  assign FLASHREQ  = fetch_act;
  assign FLASHADDR = tag_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rd_pend <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else begin
      if (HREADY) rd_pend <= act_rd;
      if (act) begin
        tag_q  <= HADDR[AW-1:2+LW];
        word_q <= addr_word;
      end
      // Wait count is captured once per read, so FLASHWS changes mid-fetch are ignored.
      if (fetch_act && cnt != '0) cnt <= cnt - 1'b1;
      else if (act_rd)            cnt <= FLASHWS;
      unique case (state)
        ST_IDLE: begin
          if (fetch_act && cnt != '0) state <= ST_FETCH;
          else if (act_wr)            state <= ST_ERR1;
        end
        ST_FETCH: if (cnt == '0) state <= act_wr ? ST_ERR1 : ST_IDLE;
        ST_ERR1:  state <= ST_ERR2;
        ST_ERR2:  state <= act_wr ? ST_ERR1 : ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  cmsdk_flash_line_buffer #(.TW(TW), .LW(LW), .FW(FW), .WSEL(WSEL)) u_line (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .lookup_tag (tag_q),
    .word_sel   (word_q),
    .fetching   (fetch_act),
    .fill       (fill),
    .inv        (FLASHINV),
    .fill_tag   (tag_q),
    .fill_data  (FLASHRDATA),
    .hit        (hit),
    .buf_word   (buf_word),
    .fill_word  (fill_word)
  );

`ifdef ARM_AHB_ASSERT_ON
  a_aw_range: assert property (@(posedge HCLK) (AW >= 8) && (AW <= 32));
  a_lw_range: assert property (@(posedge HCLK) (LW >= 0) && (LW <= 3));
`endif
endmodule

// File: tb/tb_cmsdk_ahb_to_flash_linebuf.sv
// Randomized and directed bench for the flash line-buffer bridge, checked
// against a tag/valid model and a synthetic flash content function.
module tb_cmsdk_ahb_to_flash_linebuf;
  localparam int AW = 16;
  localparam int LW = 2;
  localparam int FW = 128;

  logic           HCLK = 1'b0;
  logic           HRESETn;
  logic           HSEL;
  logic [AW-1:0]  HADDR;
  logic [1:0]     HTRANS;
  logic [2:0]     HSIZE;
  logic [3:0]     HPROT;
  logic           HWRITE;
  logic [31:0]    HWDATA;
  logic           HREADY;
  logic           HREADYOUT;
  logic           HRESP;
  logic [31:0]    HRDATA;
  logic [1:0]     FLASHWS;
  logic           FLASHINV;
  logic           FLASHREQ;
  logic [11:0]    FLASHADDR;
  logic [FW-1:0]  FLASHRDATA;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] seed;
  logic        mvalid;
  logic [11:0] mtag;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  function automatic logic [FW-1:0] flash_line(input logic [11:0] la, input logic [31:0] s);
    logic [FW-1:0] l;
    for (int i = 0; i < 4; i++)
      l[i*32 +: 32] = ({20'h0, la} * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B) ^ s;
    return l;
  endfunction

  always_comb FLASHRDATA = flash_line(FLASHADDR, seed);

  cmsdk_ahb_to_flash_linebuf #(.AW(AW), .LW(LW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .FLASHWS(FLASHWS),
    .FLASHINV(FLASHINV), .FLASHREQ(FLASHREQ), .FLASHADDR(FLASHADDR), .FLASHRDATA(FLASHRDATA)
  );

  // Read of address a. Entered and left at a negedge so reads chain back-to-back.
  task automatic do_read(input logic [15:0] a, input int ws, input int inv_cyc,
                         input int chg_ws, input string nm);
    logic [11:0]   t;
    int            w, exp_cyc, k;
    bit            h, done;
    logic [FW-1:0] ln;
    logic [31:0]   exp_d;
    t = a[15:4];
    w = int'(a[3:2]);
    h = mvalid && (mtag == t);
    exp_cyc = h ? 1 : ws + 1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; FLASHWS = 2'(ws);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    k = 0; done = 0;
    while (!done && k < 20) begin
      k++;
      FLASHINV = (k == inv_cyc);
      if (k == 2 && chg_ws >= 0) FLASHWS = 2'(chg_ws);
      @(negedge HCLK);
      checks++;
      if (FLASHREQ !== !h) begin
        failures++; $display("FAIL %s flashreq cyc%0d got %0b want %0b", nm, k, FLASHREQ, !h);
      end
      if (!h) begin
        checks++;
        if (FLASHADDR !== t) begin
          failures++; $display("FAIL %s flashaddr got %h want %h", nm, FLASHADDR, t);
        end
      end
      checks++;
      if (HRESP !== 1'b0) begin
        failures++; $display("FAIL %s hresp got %0b want 0", nm, HRESP);
      end
      if (HREADYOUT === 1'b1) done = 1;
      else begin
        checks++;
        if (HRDATA !== 32'h0) begin
          failures++; $display("FAIL %s hrdata_wait got %h want 0", nm, HRDATA);
        end
        @(posedge HCLK); #1;
      end
    end
    checks++;
    if (!done || k != exp_cyc) begin
      failures++; $display("FAIL %s cycles got %0d want %0d", nm, k, exp_cyc);
    end
    if (done) begin
      ln = flash_line(t, seed);
      exp_d = ln[w*32 +: 32];
      checks++;
      if (HRDATA !== exp_d) begin
        failures++; $display("FAIL %s hrdata got %h want %h", nm, HRDATA, exp_d);
      end
    end
    if (h) begin
      if (inv_cyc == 1) mvalid = 1'b0;
    end else begin
      mtag = t;
      mvalid = (inv_cyc == 0);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input string nm);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    FLASHINV = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, FLASHREQ} !== 3'b010 || HRDATA !== 32'h0) begin
      failures++; $display("FAIL %s err1 rdy/resp/req got %b want 010 hrdata %h", nm,
                           {HREADYOUT, HRESP, FLASHREQ}, HRDATA);
    end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, FLASHREQ} !== 3'b110) begin
      failures++; $display("FAIL %s err2 rdy/resp/req got %b want 110", nm,
                           {HREADYOUT, HRESP, FLASHREQ});
    end
  endtask

  task automatic do_idle(input logic sel, input logic [1:0] trans, input string nm);
    HSEL = sel; HTRANS = trans; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    FLASHINV = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    checks++;
    if ({HREADYOUT, HRESP, FLASHREQ} !== 3'b100 || HRDATA !== 32'h0) begin
      failures++; $display("FAIL %s idle rdy/resp/req got %b want 100 hrdata %h", nm,
                           {HREADYOUT, HRESP, FLASHREQ}, HRDATA);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if ({HREADYOUT, HRESP, FLASHREQ} !== 3'b100 || HRDATA !== 32'h0 || FLASHADDR !== 12'h0) begin
      failures++; $display("FAIL %s rdy/resp/req got %b want 100 hrdata %h flashaddr %h", nm,
                           {HREADYOUT, HRESP, FLASHREQ}, HRDATA, FLASHADDR);
    end
  endtask

  task automatic test_reset();
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010;
    HPROT = 4'h3; HWRITE = 1'b0; HWDATA = 32'hDEADBEEF; FLASHWS = 2'd0; FLASHINV = 1'b0;
    mvalid = 1'b0; mtag = '0;
    repeat (3) @(negedge HCLK);
    check_reset_outputs("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);
    check_reset_outputs("post_reset");
  endtask

  task automatic test_directed();
    do_read(16'h0104, 1, 0, -1, "miss_0104");
    do_read(16'h0108, 1, 0, -1, "hit_0108");
    do_write(16'h0100, "write_0100");
    do_read(16'h0100, 2, 0, -1, "hit_after_write");
    do_read(16'h0200, 3, 0, 0, "miss_ws3_chg");
    do_read(16'h0300, 2, 3, -1, "miss_inv_last");
    do_read(16'h0300, 0, 0, -1, "reread_after_inv");
    do_read(16'h0304, 0, 1, -1, "hit_inv");
    do_read(16'h0308, 1, 0, -1, "miss_after_hit_inv");
    do_idle(1'b1, 2'b01, "busy_sel");
    do_idle(1'b1, 2'b00, "idle_sel");
    do_idle(1'b0, 2'b10, "unselected");
  endtask

  task automatic test_back_to_back();
    do_read(16'h0400, 2, 0, -1, "b2b_miss");
    do_read(16'h0404, 3, 0, -1, "b2b_hit1");
    do_read(16'h040C, 0, 0, -1, "b2b_hit2");
    do_read(16'h0410, 0, 0, -1, "b2b_miss0ws");
    do_write(16'h0414, "b2b_write");
    do_read(16'h0418, 1, 0, -1, "b2b_hit_after_err");
    do_idle(1'b0, 2'b00, "b2b_idle");
  endtask

  task automatic test_reset_mid_fetch();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 16'h0500; FLASHWS = 2'd3;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_fetch");
    @(negedge HCLK);
    HRESETn = 1'b1;
    mvalid = 1'b0;
    do_read(16'h0504, 1, 0, -1, "after_reset_miss");
    do_read(16'h0508, 1, 0, -1, "after_reset_hit");
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [15:0] a;
      int r, ws, inv, chg, ec;
      bit h;
      r  = int'($urandom_range(0, 9));
      a  = {4'h6, 6'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      ws = int'($urandom_range(0, 3));
      h  = mvalid && (mtag == a[15:4]);
      ec = h ? 1 : ws + 1;
      inv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ec)) : 0;
      chg = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : -1;
      if (r < 2)       do_write(a, "rnd_write");
      else if (r == 2) do_idle(1'b1, 2'($urandom_range(0, 1)), "rnd_idle");
      else             do_read(a, ws, inv, chg, "rnd_read");
    end
  endtask

  initial begin
    seed = $urandom;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
